// File: rtl/packed_fifo_multi_pkg.sv
// Shared constants and helpers for the packed multi-channel FIFO.
package packed_fifo_pkg;

   localparam int DEF_LOG_N     = 2;
   localparam int DEF_WIDTH     = 36;
   localparam int DEF_LOG_DEPTH = 6;

   localparam int N     = 1 << DEF_LOG_N;
   localparam int DEPTH = 1 << DEF_LOG_DEPTH;
   localparam int CNT_W = DEF_LOG_DEPTH + 1;

   // Bit offset of channel c inside a flattened N*w data bus.
   function automatic int slice_base(input int c, input int w);
      return c * w;
   endfunction

endpackage

// File: rtl/packed_fifo_multi_if.sv
// Command/status bundle between the router stage and the packed FIFO.
interface packed_fifo_multi_if
   import packed_fifo_pkg::*;
#(
   parameter int LOG_N     = DEF_LOG_N,
   parameter int WIDTH     = DEF_WIDTH,
   parameter int LOG_DEPTH = DEF_LOG_DEPTH
);
   localparam int NCH = 1 << LOG_N;
   localparam int CW  = LOG_DEPTH + 1;

   logic                 write;
   logic [LOG_N-1:0]     wid;
   logic [WIDTH-1:0]     data_in;
   logic                 read;
   logic [LOG_N-1:0]     rid;
   logic                 flush;
   logic [LOG_N-1:0]     flush_id;
   logic                 error_clear;
   logic [NCH*WIDTH-1:0] data_out;
   logic [NCH-1:0]       has_data;
   logic [NCH-1:0]       full;
   logic [NCH-1:0]       almost_full;
   logic [NCH*CW-1:0]    count;
   logic [NCH-1:0]       overflow;
   logic [NCH-1:0]       underflow;

   modport master (
      output write, wid, data_in, read, rid, flush, flush_id, error_clear,
      input  data_out, has_data, full, almost_full, count, overflow, underflow
   );

   modport slave (
      input  write, wid, data_in, read, rid, flush, flush_id, error_clear,
      output data_out, has_data, full, almost_full, count, overflow, underflow
   );

endinterface

// File: rtl/dual_bram.sv
// Simple dual-port block RAM: one write port, one registered read port.
module DualBRAM #(
   parameter int WIDTH   = 36,
   parameter int LOG_DEP = 8
) (
   input  logic               clock,
   input  logic               we,
   input  logic [LOG_DEP-1:0] waddr,
   input  logic [WIDTH-1:0]   wdata,
   input  logic [LOG_DEP-1:0] raddr,
   output logic [WIDTH-1:0]   rdata
);
   logic [WIDTH-1:0] mem [1<<LOG_DEP];

   // Write port and 1-cycle-latency read port; no reset on the array.
   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/packed_fifo_multi_chan_ctrl.sv
// Per-channel bookkeeping: pointers, occupancy, head-register state and errors.
module packed_fifo_chan_ctrl
   import packed_fifo_pkg::*;
#(
   parameter int LOG_DEPTH   = DEF_LOG_DEPTH,
   parameter int AFULL_LEVEL = (1 << DEF_LOG_DEPTH) - 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 wr_hit,
   input  logic                 rd_hit,
   input  logic                 fl_hit,
   input  logic                 error_clear,
   output logic [LOG_DEPTH-1:0] head,
   output logic [LOG_DEPTH-1:0] tail,
   output logic [LOG_DEPTH:0]   count,
   output logic                 has_data,
   output logic                 full,
   output logic                 almost_full,
   output logic                 overflow,
   output logic                 underflow,
   output logic                 ram_we,
   output logic                 ld_wdata,
   output logic                 ld_rdata
);
   localparam int CW  = LOG_DEPTH + 1;
   localparam int DEP = 1 << LOG_DEPTH;

   logic          valid, pending;
   logic          w_acc, r_acc, ram_empty, direct, bypass, refill;
   logic [CW-1:0] ram_cnt;

   assign full        = (count == CW'(DEP + 1));
   assign almost_full = (count >= CW'(AFULL_LEVEL));
   assign has_data    = valid;

   // Accept/route decision; a write only reaches the head register when
   // nothing older can still be waiting in RAM or in the refill pipe.
   assign w_acc     = wr_hit & ~full & ~fl_hit;
   assign r_acc     = rd_hit & valid & ~fl_hit;
   assign ram_cnt   = count - CW'(valid) - CW'(pending);
   assign ram_empty = (ram_cnt == '0);
   assign direct    = w_acc & ~valid & ~pending & ram_empty;
   assign bypass    = w_acc & r_acc & ~pending & ram_empty;
   assign ram_we    = w_acc & ~direct & ~bypass;
   assign refill    = r_acc & ~ram_empty;
   assign ld_wdata  = direct | bypass;
   assign ld_rdata  = pending & ~fl_hit;

   // Pointer, occupancy and head-register state; flush resets the channel.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         valid   <= 1'b0;
         pending <= 1'b0;
      end else if (fl_hit) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         valid   <= 1'b0;
         pending <= 1'b0;
      end else begin
         if (ram_we) tail <= tail + 1'b1;
         if (refill) head <= head + 1'b1;
         count   <= count + CW'(w_acc) - CW'(r_acc);
         pending <= refill;
         valid   <= ld_rdata | ld_wdata | (valid & ~r_acc);
      end
   end

   // Sticky error flags; a fresh error outranks a same-cycle clear.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= (wr_hit & full & ~fl_hit) | (overflow & ~error_clear);
         underflow <= (rd_hit & ~valid & ~fl_hit) | (underflow & ~error_clear);
      end
   end

endmodule

// File: rtl/packed_fifo_multi.sv
// N FIFO channels sharing one block RAM, each with a prefetched head register.
module packed_fifo_multi
   import packed_fifo_pkg::*;
#(
   parameter int LOG_N       = DEF_LOG_N,
   parameter int WIDTH       = DEF_WIDTH,
   parameter int LOG_DEPTH   = DEF_LOG_DEPTH,
   parameter int AFULL_LEVEL = (1 << LOG_DEPTH) - 4
) (
   input  logic          clock,
   input  logic          reset,
   packed_fifo_multi_if.slave bus
);
   localparam int NCH = 1 << LOG_N;
   localparam int CW  = LOG_DEPTH + 1;
   localparam int AW  = LOG_N + LOG_DEPTH;

   logic [NCH-1:0]       wr_hit, rd_hit, fl_hit;
   logic                 ram_we_a [NCH];
   logic                 ld_wdata [NCH];
   logic                 ld_rdata [NCH];
   logic                 hd_a [NCH], full_a [NCH], af_a [NCH], ov_a [NCH], un_a [NCH];
   logic [CW-1:0]        cnt_a [NCH];
   logic [LOG_DEPTH-1:0] head_a [NCH];
   logic [LOG_DEPTH-1:0] tail_a [NCH];
   logic [WIDTH-1:0]     out_reg [NCH];
   logic [WIDTH-1:0]     rdata;
   logic [AW-1:0]        waddr, raddr;
   logic                 ram_we;

   // One-hot channel decoders for the three command streams.
   always_comb begin
      wr_hit = '0;
      rd_hit = '0;
      fl_hit = '0;
      wr_hit[bus.wid]      = bus.write;
      rd_hit[bus.rid]      = bus.read;
      fl_hit[bus.flush_id] = bus.flush;
   end

   // Channel index forms the RAM address MSBs; only the addressed channel can write.
   always_comb begin
      ram_we = 1'b0;
      for (int c = 0; c < NCH; c++) ram_we = ram_we | ram_we_a[c];
      waddr = {bus.wid, tail_a[bus.wid]};
      raddr = {bus.rid, head_a[bus.rid]};
   end

   DualBRAM #(.WIDTH(WIDTH), .LOG_DEP(AW)) u_ram (
      .clock (clock),
      .we    (ram_we),
      .waddr (waddr),
      .wdata (bus.data_in),
      .raddr (raddr),
      .rdata (rdata)
   );

   for (genvar c = 0; c < NCH; c++) begin : g_chan
      packed_fifo_chan_ctrl #(.LOG_DEPTH(LOG_DEPTH), .AFULL_LEVEL(AFULL_LEVEL)) u_ctrl (
         .clock       (clock),
         .reset       (reset),
         .wr_hit      (wr_hit[c]),
         .rd_hit      (rd_hit[c]),
         .fl_hit      (fl_hit[c]),
         .error_clear (bus.error_clear),
         .head        (head_a[c]),
         .tail        (tail_a[c]),
         .count       (cnt_a[c]),
         .has_data    (hd_a[c]),
         .full        (full_a[c]),
         .almost_full (af_a[c]),
         .overflow    (ov_a[c]),
         .underflow   (un_a[c]),
         .ram_we      (ram_we_a[c]),
         .ld_wdata    (ld_wdata[c]),
         .ld_rdata    (ld_rdata[c])
      );

      // Head register: loaded by a returning refill or by a direct/bypass write.
      always_ff @(posedge clock or negedge reset) begin
         if (!reset)           out_reg[c] <= '0;
         else if (ld_rdata[c]) out_reg[c] <= rdata;
         else if (ld_wdata[c]) out_reg[c] <= bus.data_in;
      end
   end

   // Flatten per-channel status onto the interface buses.
   always_comb begin
      bus.data_out    = '0;
      bus.count       = '0;
      bus.has_data    = '0;
      bus.full        = '0;
      bus.almost_full = '0;
      bus.overflow    = '0;
      bus.underflow   = '0;
      for (int c = 0; c < NCH; c++) begin
         bus.data_out[slice_base(c, WIDTH) +: WIDTH] = out_reg[c];
         bus.count[c*CW +: CW] = cnt_a[c];
         bus.has_data[c]       = hd_a[c];
         bus.full[c]           = full_a[c];
         bus.almost_full[c]    = af_a[c];
         bus.overflow[c]       = ov_a[c];
         bus.underflow[c]      = un_a[c];
      end
   end

endmodule

// File: tb/tb_packed_fifo_multi.sv
// Scoreboard bench for packed_fifo_multi against a queue-based channel model.
module tb_packed_fifo_multi;
   import packed_fifo_pkg::*;

   localparam int LN  = 2;
   localparam int W   = 36;
   localparam int LD  = 6;
   localparam int NC  = 1 << LN;
   localparam int CW  = LD + 1;
   localparam int CAP = (1 << LD) + 1;
   localparam int AF  = (1 << LD) - 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;

   // Reference model: each channel is just a queue of words plus a flag for
   // the one-cycle head gap that follows a pop with more words behind it.
   logic [W-1:0] mq [NC][$];
   bit           gap [NC];
   bit           m_ov [NC];
   bit           m_un [NC];

   int           exp_ch [$];
   logic [W-1:0] exp_dat [$];

   packed_fifo_multi_if #(.LOG_N(LN), .WIDTH(W), .LOG_DEPTH(LD)) bus ();

   packed_fifo_multi #(.LOG_N(LN), .WIDTH(W), .LOG_DEPTH(LD), .AFULL_LEVEL(AF)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit mhd(input int c);
      return (mq[c].size() > 0) && !gap[c];
   endfunction

   function automatic logic [W-1:0] dslice(input int c);
      return bus.data_out[c*W +: W];
   endfunction

   function automatic logic [63:0] cnt_of(input int c);
      return 64'(bus.count[c*CW +: CW]);
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NC; c++) begin
         mq[c].delete();
         gap[c]  = 1'b0;
         m_ov[c] = 1'b0;
         m_un[c] = 1'b0;
      end
   endtask

   task automatic model_step();
      for (int c = 0; c < NC; c++) begin
         bit fl, wr, rd, hd;
         int sz;
         fl = bus.flush && (int'(bus.flush_id) == c);
         wr = bus.write && (int'(bus.wid) == c);
         rd = bus.read && (int'(bus.rid) == c);
         sz = mq[c].size();
         hd = mhd(c);
         if (bus.error_clear) begin
            m_ov[c] = 1'b0;
            m_un[c] = 1'b0;
         end
         if (fl) begin
            mq[c].delete();
            gap[c] = 1'b0;
         end else begin
            if (wr && sz == CAP) m_ov[c] = 1'b1;
            if (rd && !hd)       m_un[c] = 1'b1;
            gap[c] = rd && hd && (sz >= 2);
            if (wr && sz < CAP) mq[c].push_back(bus.data_in);
            if (rd && hd)       void'(mq[c].pop_front());
         end
      end
   endtask

   always @(posedge clock or negedge reset) begin
      if (!reset) model_reset();
      else        model_step();
   end

   task automatic monitor_step();
      logic [63:0]  e_hd, e_full, e_af, e_ov, e_un, e_cnt;
      int           r, c0;
      logic [W-1:0] d0;
      e_hd = '0; e_full = '0; e_af = '0; e_ov = '0; e_un = '0; e_cnt = '0;
      for (int c = 0; c < NC; c++) begin
         e_hd[c]   = mhd(c);
         e_full[c] = (mq[c].size() == CAP);
         e_af[c]   = (mq[c].size() >= AF);
         e_ov[c]   = m_ov[c];
         e_un[c]   = m_un[c];
         e_cnt[c*CW +: CW] = CW'(mq[c].size());
      end
      check("has_data",    64'(bus.has_data),    e_hd);
      check("full",        64'(bus.full),        e_full);
      check("almost_full", 64'(bus.almost_full), e_af);
      check("overflow",    64'(bus.overflow),    e_ov);
      check("underflow",   64'(bus.underflow),   e_un);
      check("count",       64'(bus.count),       e_cnt);
      for (int c = 0; c < NC; c++)
         if (mhd(c)) check("head_word", 64'(dslice(c)), 64'(mq[c][0]));
      r = int'(bus.rid);
      if (bus.read && bus.has_data[r] && !(bus.flush && int'(bus.flush_id) == r)) begin
         if (exp_dat.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL pop_unexpected: ch %0d presented %0h with nothing expected", r, dslice(r));
         end else begin
            c0 = exp_ch.pop_front();
            d0 = exp_dat.pop_front();
            check("pop_channel", 64'(r), 64'(c0));
            check("pop_data", 64'(dslice(r)), 64'(d0));
         end
      end
   endtask

   always @(negedge clock) if (reset) monitor_step();

   task automatic set_cmd(input bit w, input int wc, input logic [W-1:0] d, input bit r,
                          input int rc, input bit f, input int fc, input bit ec);
      bus.write = w;  bus.wid = LN'(wc);  bus.data_in = d;
      bus.read = r;   bus.rid = LN'(rc);
      bus.flush = f;  bus.flush_id = LN'(fc);
      bus.error_clear = ec;
   endtask

   task automatic drive(input bit w, input int wc, input logic [W-1:0] d, input bit r,
                        input int rc, input bit f, input int fc, input bit ec);
      set_cmd(w, wc, d, r, rc, f, fc, ec);
      if (r && mhd(rc) && !(f && fc == rc)) begin
         exp_ch.push_back(rc);
         exp_dat.push_back(mq[rc][0]);
      end
      @(posedge clock);
      #2;
   endtask

   task automatic wr(input int c, input logic [W-1:0] d); drive(1, c, d, 0, 0, 0, 0, 0); endtask
   task automatic rd(input int c);                        drive(0, 0, '0, 1, c, 0, 0, 0); endtask
   task automatic fl(input int c);                        drive(0, 0, '0, 0, 0, 1, c, 0); endtask
   task automatic idle();                                 drive(0, 0, '0, 0, 0, 0, 0, 0); endtask

   initial begin
      int n;
      set_cmd(0, 0, '0, 0, 0, 0, 0, 0);
      #1 reset = 1'b0;
      #1;
      check("rst_data_out", 64'(bus.data_out != '0), 64'(0));
      check("rst_flags", 64'({bus.has_data, bus.full, bus.almost_full, bus.overflow, bus.underflow}), 64'(0));
      check("rst_count", 64'(bus.count), 64'(0));
      @(posedge clock);
      @(posedge clock);
      #2 reset = 1'b1;

      // ordering through the RAM with refill gaps
      wr(0, 1); wr(0, 2); wr(0, 3);
      n = 0;
      for (int k = 0; k < 12 && n < 3; k++) begin
         if (mhd(0)) begin rd(0); n++; end
         else idle();
      end
      check("order_pop_count", 64'(n), 64'(3));
      idle();
      check("order_empty", cnt_of(0), 64'(0));

      // back-to-back pops on different channels
      wr(0, 'h10); wr(0, 'h11); wr(2, 'h20); wr(2, 'h21); idle();
      rd(0);
      check("ileave_gap0", 64'(bus.has_data[0]), 64'(0));
      check("ileave_hd2", 64'(bus.has_data[2]), 64'(1));
      rd(2);
      check("ileave_head0", 64'(dslice(0)), 64'('h11));
      idle(); idle();

      // bypass on a single-word channel
      wr(3, 5); idle();
      drive(1, 3, 6, 1, 3, 0, 0, 0);
      check("bypass_data", 64'(dslice(3)), 64'(6));
      check("bypass_count", cnt_of(3), 64'(1));

      // fill to capacity, overflow, underflow, clear
      for (int k = 0; k < CAP; k++) wr(1, W'('h100 + k));
      check("full1", 64'(bus.full[1]), 64'(1));
      wr(1, 'hDEAD);
      check("ovf1", 64'(bus.overflow[1]), 64'(1));
      check("ovf_count", cnt_of(1), 64'(CAP));
      fl(2);
      rd(2);
      check("unf2", 64'(bus.underflow[2]), 64'(1));
      drive(0, 0, '0, 0, 0, 0, 0, 1);
      check("err_clear", 64'({bus.overflow[1], bus.underflow[2]}), 64'(0));

      // flush while a refill is in flight
      wr(0, 'h30); wr(0, 'h31);
      rd(0);
      fl(0);
      check("flush_cnt0", cnt_of(0), 64'(0));
      check("flush_hd0", 64'(bus.has_data[0]), 64'(0));
      check("flush_ch1", cnt_of(1), 64'(CAP));
      idle();
      check("flush_discard", 64'(bus.has_data[0]), 64'(0));
      fl(1);

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         drive($urandom_range(0, 99) < 55, $urandom_range(0, NC-1), W'({$urandom(), $urandom()}),
               $urandom_range(0, 99) < 50, $urandom_range(0, NC-1),
               $urandom_range(0, 99) < 2,  $urandom_range(0, NC-1),
               $urandom_range(0, 99) < 3);
      end
      idle();

      // asynchronous reset mid-stream
      fl(1);
      wr(1, 'h71); wr(1, 'h72); wr(1, 'h73); idle();
      check("pre_reset_cnt1", cnt_of(1), 64'(3));
      reset = 1'b0;
      #1;
      check("mid_rst_data", 64'(bus.data_out != '0), 64'(0));
      check("mid_rst_flags", 64'({bus.has_data, bus.full, bus.almost_full, bus.overflow, bus.underflow}), 64'(0));
      check("mid_rst_count", 64'(bus.count), 64'(0));
      @(posedge clock);
      @(posedge clock);
      #2 reset = 1'b1;
      wr(1, 'hA);
      check("post_rst_hd1", 64'(bus.has_data[1]), 64'(1));
      check("post_rst_data1", 64'(dslice(1)), 64'('hA));
      idle(); idle();
      check("sb_drained", 64'(exp_dat.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/packed_fifo_multi.md
Name: packed_fifo_multi

Overview:
- N independent FIFO channels packed into one simple-dual-port block RAM, each with a private prefetch output register, so every channel's head word is always visible on data_out.
- Next-generation packed FIFO, differing from the current one in four ways:
  - the refill stall is per channel instead of global;
  - overflow and underflow are detected and reported;
  - channels can be flushed individually;
  - each channel exposes an occupancy count and an almost-full flag.
- Sits between the router/arbiter stage and per-port consumers.

Parameters:
- LOG_N, 2, log2 of channel count; N = 1<<LOG_N.
- WIDTH, 36, data word width.
- LOG_DEPTH, 6, log2 of RAM entries per channel; DEPTH = 1<<LOG_DEPTH.
- AFULL_LEVEL, DEPTH-4, occupancy at or above which almost_full[c] is asserted.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- write  in  1  push data_in into channel wid.
- wid  in  LOG_N  write channel.
- data_in  in  WIDTH  write data.
- read  in  1  pop head of channel rid.
- rid  in  LOG_N  read channel.
- flush  in  1  empty channel flush_id.
- flush_id  in  LOG_N  flush channel.
- error_clear  in  1  clear sticky error flags.
- data_out  out  N*WIDTH  head word of channel c at [c*WIDTH +: WIDTH].
- has_data  out  N  head word of channel c is valid and poppable this cycle.
- full  out  N  count[c] == DEPTH+1.
- almost_full  out  N  count[c] >= AFULL_LEVEL.
- count  out  N*(LOG_DEPTH+1)  per-channel occupancy, 0..DEPTH+1.
- overflow  out  N  sticky: a write arrived while full.
- underflow  out  N  sticky: a read arrived while has_data was 0.

Behaviour:

Storage per channel:
- Output register plus a RAM region at address {c, ptr}.
- Pointers are binary, LOG_DEPTH bits, and wrap modulo DEPTH.
- RAM read is synchronous with 1-cycle latency. Writes use the same-cycle write port.

Occupancy:
- count[c] = RAM entries + output-valid + refill-pending.

Reset (clock-independent):
- All pointers, counts, valid bits, pending bits and sticky flags go to 0.
- data_out = 0.
- has_data = 0, full = 0, almost_full = 0, overflow = 0, underflow = 0.
- On deassertion: the first accepted write is at the first rising edge after reset goes high.

Write to channel c:
- Rejected if full[c]: data is dropped and overflow[c] is set. A simultaneous read to c does not rescue the write.
- Otherwise the destination is chosen as follows:
  - Output register, if its valid bit is 0 AND no refill is pending AND the RAM region is empty.
  - Also the output register, if the same cycle pops c while the RAM region is empty and no refill is pending (bypass).
  - The RAM tail in all other cases.
- The word appears on data_out / has_data the cycle after it is written into the output register.

Read of channel c:
- Legal only when has_data[c] = 1; otherwise the read is ignored and underflow[c] is set.
- If the RAM region is non-empty: issue a RAM read of the head, advance head, set refill-pending[c].
- has_data[c] = 0 for exactly the one cycle in which the refill is in flight. The refill data loads the output register on the next edge.
- The RAM read port is pipelined, so a read of a different channel d != c is accepted in the refill cycle. There is no global busy.
- If the RAM region is empty and there is no bypass write: the output valid bit clears.

Order preservation:
- A word written to RAM is never overtaken by a later direct or bypass load.
- The destination rule above guarantees this, including a write arriving during a pending refill, which goes to RAM.

Count update:
- count[c] += write accepted; -= read accepted. Both in the same cycle leave it unchanged.

Flush of channel c:
- Single cycle: head = tail = 0, valid = 0, pending = 0, count = 0. A refill returning next cycle for c is discarded.
- Flush beats a same-cycle read/write to c: these are dropped silently, with no error flag.
- Other channels are unaffected.

Error flags:
- error_clear zeroes overflow and underflow.
- A new error in the same cycle as error_clear wins, so the flag stays set.

Simultaneous events:
- Write and read on different channels proceed independently.
- Any combination of the three commands targeting three channels is legal.

Decomposition:
- Package packed_fifo_pkg: constants for N, DEPTH, CNT_W = LOG_DEPTH+1, and a function giving the channel slice base (c*WIDTH).
- Sub-module packed_fifo_chan_ctrl, one instance per channel via generate, owns:
  - head/tail pointers, count, valid and pending bits;
  - the destination decision (direct / bypass / RAM);
  - full, almost_full and the sticky error bits.
- Top level holds:
  - the wid/rid/flush_id decoders;
  - the RAM address muxes (channel index forms the address MSBs);
  - the output registers;
  - one instance of the team's DualBRAM with LOG_DEP = LOG_N+LOG_DEPTH.

Test Plan:
- Reset mid-stream: hold reset low with ch1 count=3 -> all outputs 0 immediately, without a clock edge. After release, write 0xA to ch1 -> has_data[1]=1 and data_out ch1 = 0xA next cycle.
- Ordering: write 1,2,3 to ch0, then read 3 times on consecutive eligible cycles -> pops 1,2,3. has_data[0] is low one cycle after each RAM-backed pop. count goes 3,2,1,0.
- Interleaved channels: pop ch0 (RAM-backed), next cycle pop ch2 -> both accepted with no stall. ch2 head is correct.
- Bypass: ch3 holds one word 0x5 (RAM empty); read and write 0x6 on ch3 in the same cycle -> next cycle data_out ch3 = 0x6, count stays 1.
- Full and errors:
  - Fill ch1 to 65 (LOG_DEPTH=6) -> full[1]=1; almost_full[1] asserted from count 60.
  - Write once more -> overflow[1]=1, count stays 65.
  - Read ch2 while empty -> underflow[2]=1.
  - error_clear -> both flags 0.
- Flush during refill: pop ch0 (refill pending) and flush ch0 next cycle -> refill discarded, count=0, has_data[0]=0. Other channels unchanged.
